// File: rtl/scr1_clk_ctrl_mc.sv
// Multi-channel clock controller: per-channel sleep/wake FSM with idle hysteresis
// and wake settle delay, each driving a glitch-free latch-based clock gate.

module scr1_cg (
   input  logic clk,
   input  logic clk_en,
   input  logic test_mode,
   output logic clk_out
);
   logic en_lat;

   // Enable captured while clk is low so clk_out can only change on a clk edge
   always_latch begin
      if (!clk) en_lat <= clk_en | test_mode;
   end

   assign clk_out = clk & en_lat;
endmodule

module scr1_clk_ctrl_ch #(
   parameter int IDLE_CYC = 4,
   parameter int WAKE_CYC = 2,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic sleep_req,
   input  logic wake_req,
   output logic ch_en,
   output logic ch_ready,
   output logic ch_off
);
   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_OFF, ST_WAKE} state_t;

   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((IDLE_CYC > 0) ? IDLE_CYC - 1 : 0);
   localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYC > 0) ? WAKE_CYC - 1 : 0);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Wake has priority over sleep everywhere; WAKE itself cannot be aborted
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_RUN: begin
            if (sleep_req && !wake_req) begin
               state_nx = (IDLE_CYC == 0) ? ST_OFF : ST_DRAIN;
               cnt_nx   = '0;
            end
         end
         ST_DRAIN: begin
            if (wake_req || !sleep_req) begin
               state_nx = ST_RUN;
               cnt_nx   = '0;
            end else if (cnt == IDLE_LAST) begin
               state_nx = ST_OFF;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         ST_OFF: begin
            if (wake_req) begin
               state_nx = (WAKE_CYC == 0) ? ST_RUN : ST_WAKE;
               cnt_nx   = '0;
            end
         end
         ST_WAKE: begin
            if (cnt == WAKE_LAST) begin
               state_nx = ST_RUN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = ST_RUN;
            cnt_nx   = '0;
         end
      endcase
   end

   assign ch_en    = (state != ST_OFF);
   assign ch_ready = (state == ST_RUN);
   assign ch_off   = (state == ST_OFF);
endmodule

module scr1_clk_ctrl_mc #(
   parameter int NUM_CH   = 4,
   parameter int IDLE_CYC = 4,
   parameter int WAKE_CYC = 2,
   parameter int CNT_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              test_mode,
   input  logic [NUM_CH-1:0] sleep_req,
   input  logic [NUM_CH-1:0] wake_req,
   output logic              clkout,
   output logic              clkout_dbgc,
   output logic [NUM_CH-1:0] clkout_ch,
   output logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] ch_ready,
   output logic [NUM_CH-1:0] ch_off
);
   localparam int MAX_CYC = (IDLE_CYC > WAKE_CYC) ? IDLE_CYC : WAKE_CYC;

   generate
      if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
         $error("scr1_clk_ctrl_mc: NUM_CH must be 1..16");
      end
      if (CNT_W < $clog2(MAX_CYC + 1) || CNT_W < 1) begin : g_bad_cnt_w
         $error("scr1_clk_ctrl_mc: CNT_W too narrow for IDLE_CYC/WAKE_CYC");
      end
   endgenerate

   assign clkout      = clk;
   assign clkout_dbgc = clk;

   genvar i;
   generate
      for (i = 0; i < NUM_CH; i++) begin : g_ch
         scr1_clk_ctrl_ch #(
            .IDLE_CYC (IDLE_CYC),
            .WAKE_CYC (WAKE_CYC),
            .CNT_W    (CNT_W)
         ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sleep_req (sleep_req[i]),
            .wake_req  (wake_req[i]),
            .ch_en     (ch_en[i]),
            .ch_ready  (ch_ready[i]),
            .ch_off    (ch_off[i])
         );

         scr1_cg u_cg (
            .clk       (clk),
            .clk_en    (ch_en[i]),
            .test_mode (test_mode),
            .clk_out   (clkout_ch[i])
         );
      end
   endgenerate
endmodule
